branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side branch predictor that produces the next-PC guess resolved later by the execute-stage branch comparator.
- Combines a bimodal table of 2-bit saturating counters with a direct-mapped, tagged branch target buffer (BTB).
- Prediction is combinational in the fetch cycle. Training happens on the clock edge from the resolved outcome (br_taken, actual target) returned by execute.
- Also keeps resolved-branch and mispredict counters for performance analysis.

Parameters:
IDX_BITS, 6, log2 of entry count (64 entries); index = pc[IDX_BITS+1:2]
TAG_BITS, 24, tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; must satisfy IDX_BITS+TAG_BITS <= 30
CNT_INIT, 2'b01, counter value after reset or clear (weakly not-taken)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous flush of all predictor state, same effect as rst on tables only
fetch_pc  input  32  PC being fetched
pred_taken  output  1  prediction for fetch_pc
pred_next_pc  output  32  pred_taken ? BTB target : fetch_pc+4
upd_valid  input  1  resolved branch/jump present this cycle
upd_pc  input  32  PC of resolved instruction
upd_taken  input  1  actual outcome (br_taken from execute)
upd_uncond  input  1  unconditional jump (branch type "always")
upd_target  input  32  actual taken target
upd_pred_taken  input  1  prediction made at fetch, piped with the instruction
upd_pred_target  input  32  predicted next PC, piped with the instruction
mispredict  output  1  registered one-cycle pulse: previous upd_valid cycle was mispredicted
branch_cnt  output  32  count of upd_valid cycles
mispredict_cnt  output  32  count of mispredicts

Behaviour:
- Only one clock is used. Reset is synchronous and active-high.
- Per entry state: valid (1b), tag (TAG_BITS), target (32b, word aligned), ctr (2b).
- Reset (rst=1 at edge):
  - all valid=0, all ctr=CNT_INIT;
  - mispredict=0, branch_cnt=0, mispredict_cnt=0.
  - Target and tag contents are don't-care.
- clear=1: all valid=0, all ctr=CNT_INIT. Counters and mispredict are unchanged. Any update in the same cycle is discarded; clear wins.
- Prediction (combinational, zero latency):
  - hit = valid[i] & tag[i]==fetch_pc tag field;
  - pred_taken = hit & ctr[i][1];
  - pred_next_pc = pred_taken ? target[i] : fetch_pc+4, with 32-bit wrap-around (0xFFFFFFFC -> 0x00000000).
- Update at the edge when upd_valid=1, using index j and tag from upd_pc; uhit = valid[j] & tag match:
  - upd_taken=1, uhit=1: ctr = upd_uncond ? 2'b11 : sat_inc(ctr); target[j]=upd_target.
  - upd_taken=1, uhit=0: allocate/replace. valid=1, tag, target written; ctr = upd_uncond ? 2'b11 : 2'b10.
  - upd_taken=0, uhit=1: ctr = sat_dec(ctr). Entry stays valid.
  - upd_taken=0, uhit=0: no table change.
  - Saturation: 2'b11 stays 2'b11 on increment; 2'b00 stays 2'b00 on decrement.
- Read/update collision: fetch_pc and upd_pc map to the same index in the same cycle → the prediction uses pre-update state. The new state is visible from the next cycle. There is no bypass.
- Mispredict condition: mp = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)).
  - mispredict <= mp each cycle, deasserting the cycle after.
  - Only upd_pred_* are compared; current table contents are not.
- branch_cnt increments by 1 when upd_valid; mispredict_cnt increments by 1 when mp. Both wrap modulo 2^32.
- rst has priority over clear and update. Reset mid-stream discards that cycle's update.
- Low two bits of upd_target are stored as given. Alignment is the producer's responsibility.

Test Plan:
- Reset then fetch_pc=0x100 → pred_taken=0, pred_next_pc=0x104. Counters read 0.
- Train taken: update pc=0x100, taken=1, target=0x200, pred_taken=0 → next cycle fetch 0x100 gives pred_taken=1, pred_next_pc=0x200 (ctr=10); mispredict pulses one cycle; branch_cnt=1, mispredict_cnt=1.
- Hysteresis: from ctr=10, two taken updates → ctr=11, saturated. One not-taken → still predicts taken (10). Second not-taken → predicts 0x104. Further not-takens stay at 00 with no underflow.
- Alias: train 0x100 taken. Then update pc=0x100+(1<<(IDX_BITS+2)), taken=1, target=0x300 → entry replaced. Fetch 0x100 predicts not-taken (tag miss). Fetch alias predicts 0x300.
- Same-cycle collision: fetch_pc=upd_pc=0x100 on the first taken training → pred_taken=0 that cycle, 1 the next. Unconditional update on a new pc sets ctr=11 immediately.
- clear asserted together with upd_valid for 0x180 taken → all predictions not-taken afterwards; branch_cnt and mispredict_cnt unchanged. rst asserted mid-sequence → all outputs return to reset values at the following edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: bimodal 2-bit counters plus a direct-mapped,
// tagged branch target buffer. Prediction is combinational on fetch_pc.
// Training is applied at the clock edge from resolved branches returned by
// execute. Resolved-branch and mispredict counts are kept for perf analysis.
module branch_predictor #(
    parameter int          IDX_BITS = 6,
    parameter int          TAG_BITS = 24,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_uncond,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid;
    logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
    logic [31:0]         target_mem [ENTRIES];
    logic [1:0]          ctr_mem    [ENTRIES];

    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0] fetch_tag;
    logic                fetch_hit;

    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic [1:0]          upd_ctr_cur;
    logic [1:0]          upd_ctr_next;
    logic                upd_ctr_write;
    logic                upd_entry_write;
    logic                mp;

    assign fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag = fetch_pc[TAG_HI:TAG_LO];
    assign upd_idx   = upd_pc[IDX_BITS+1:2];
    assign upd_tag   = upd_pc[TAG_HI:TAG_LO];

    // The byte-offset bits never take part in indexing or tagging.
    logic unused_lo;
    assign unused_lo = ^{fetch_pc[1:0], upd_pc[1:0]};

    // PC bits above the tag field are ignored when the tag is narrower than the PC allows.
    if (TAG_HI < 31) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{fetch_pc[31:TAG_HI+1], upd_pc[31:TAG_HI+1]};
    end

    // Fetch-side lookup reads pre-update state; there is deliberately no bypass.
    always_comb begin
        fetch_hit    = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
        pred_taken   = fetch_hit && ctr_mem[fetch_idx][1];
        pred_next_pc = pred_taken ? target_mem[fetch_idx] : (fetch_pc + 32'd4);
    end

    // Work out the next counter value and which parts of the entry this update writes.
    always_comb begin
        upd_hit      = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
        upd_ctr_cur  = ctr_mem[upd_idx];
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken) begin
            if (upd_uncond)
                upd_ctr_next = 2'b11;
            else if (upd_hit)
                upd_ctr_next = (upd_ctr_cur == 2'b11) ? 2'b11 : (upd_ctr_cur + 2'd1);
            else
                upd_ctr_next = 2'b10;
        end else if (upd_hit) begin
            upd_ctr_next = (upd_ctr_cur == 2'b00) ? 2'b00 : (upd_ctr_cur - 2'd1);
        end
        upd_ctr_write   = upd_valid && (upd_taken || upd_hit);
        upd_entry_write = upd_valid && upd_taken;
        mp = upd_valid && ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));
    end

    // Valid bits and counters: reset and clear both flush them, and an update is dropped when either is active.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_mem[i] <= CNT_INIT;
        end else begin
            if (upd_entry_write)
                valid[upd_idx] <= 1'b1;
            if (upd_ctr_write)
                ctr_mem[upd_idx] <= upd_ctr_next;
        end
    end

    // Tag and target storage is never flushed since valid=0 already hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && !clear && upd_entry_write) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
        end
    end

    // Perf counters and the mispredict pulse; clear holds them so a flush does not skew statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict     <= 1'b0;
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else if (!clear) begin
            mispredict <= mp;
            if (upd_valid)
                branch_cnt <= branch_cnt + 32'd1;
            if (mp)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule
